// File: rtl/vk_arbiter.sv
// Shared-memory port arbiter between the VGA text-read path and the keyboard ASCII producer.
// Key events are buffered in a small FIFO; VGA reads win unless the FIFO has starved too long.
module vk_arbiter #(
  parameter logic [31:0] KEY_ADDR     = 32'h0000_20D0,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned AW           = 3,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [7:0]    key_ascii,
  input  logic          vga_req,
  input  logic [31:0]   vga_addr,
  output logic [31:0]   vga_rdata,
  output logic          vga_rvalid,
  output logic [31:0]   mem_addr,
  output logic          mem_wren,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [AW:0]   fifo_count,
  output logic          fifo_full,
  output logic          overflow
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {GntIdle, GntRead, GntWrite, GntForce} gnt_e;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          overflow_q, overflow_d;
  logic          rd_inflight_q, rvalid_q;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          mem_wren_q, mem_wren_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  gnt_e gnt;
  logic fifo_nonempty, fifo_is_full, starved;
  logic key_push, push_ok, pop;
  logic [7:0] head;

  assign fifo_nonempty = (count_q != '0);
  assign fifo_is_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign starved       = (starve_q == SW'(STARVE_LIMIT));
  assign head          = fifo_mem[rd_ptr_q];

  // Grant priority: forced key write, then VGA read, then opportunistic key write.
  always_comb begin
    gnt = GntIdle;
    if (fifo_nonempty && starved) begin
      gnt = GntForce;
    end else if (vga_req) begin
      gnt = GntRead;
    end else if (fifo_nonempty) begin
      gnt = GntWrite;
    end
  end

  assign pop      = (gnt == GntWrite) || (gnt == GntForce);
  assign key_push = key_valid && (key_ascii != 8'h00);
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign push_ok  = key_push && (!fifo_is_full || pop);

  always_comb begin
    count_d    = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    overflow_d = overflow_q || (key_push && !push_ok);

    starve_d = starve_q;
    if (!fifo_nonempty || pop) begin
      starve_d = '0;
    end else if ((gnt == GntRead) && !starved) begin
      starve_d = starve_q + SW'(1);
    end

    mem_addr_d  = mem_addr_q;
    mem_wren_d  = 1'b0;
    mem_wdata_d = mem_wdata_q;
    unique case (gnt)
      GntRead: begin
        mem_addr_d = vga_addr;
      end
      GntWrite, GntForce: begin
        mem_addr_d  = KEY_ADDR;
        mem_wren_d  = 1'b1;
        mem_wdata_d = {24'h000000, head};
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= key_ascii;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      starve_q      <= '0;
      overflow_q    <= 1'b0;
      rd_inflight_q <= 1'b0;
      rvalid_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wren_q    <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q       <= count_d;
      starve_q      <= starve_d;
      overflow_q    <= overflow_d;
      rd_inflight_q <= (gnt == GntRead);
      rvalid_q      <= rd_inflight_q;
      mem_addr_q    <= mem_addr_d;
      mem_wren_q    <= mem_wren_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign vga_rdata  = mem_rdata;
  assign vga_rvalid = rvalid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wren   = mem_wren_q;
  assign mem_wdata  = mem_wdata_q;
  assign fifo_count = count_q;
  assign fifo_full  = fifo_is_full;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_vk_arbiter.sv
// Self-checking bench for vk_arbiter: directed cycle checks plus read/write scoreboards
// fed at stimulus time and drained whenever the DUT returns read data or issues a write.
module tb_vk_arbiter;

  localparam logic [31:0] KeyAddr = 32'h0000_20D0;

  logic        sys_clk;
  logic        rst;
  logic        key_valid;
  logic [7:0]  key_ascii;
  logic        vga_req;
  logic [31:0] vga_addr;
  logic [31:0] vga_rdata;
  logic        vga_rvalid;
  logic [31:0] mem_addr;
  logic        mem_wren;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [3:0]  fifo_count;
  logic        fifo_full;
  logic        overflow;

  int unsigned n_checks;
  int unsigned n_pass;

  logic [31:0] rd_exp[$];
  logic [7:0]  wr_exp[$];

  vk_arbiter dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ascii  (key_ascii),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_rdata  (vga_rdata),
    .vga_rvalid (vga_rvalid),
    .mem_addr   (mem_addr),
    .mem_wren   (mem_wren),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // RAM model: one-cycle latency, returns the address it was given.
  initial mem_rdata = 32'h0;
  always @(posedge sys_clk) mem_rdata <= mem_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard drain: every returned read and every write must match the next expectation.
  always @(negedge sys_clk) begin
    if (vga_rvalid === 1'b1) begin
      if (rd_exp.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else check("rd_data", vga_rdata, rd_exp.pop_front());
    end
    if (mem_wren === 1'b1) begin
      if (wr_exp.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        check("wr_addr", mem_addr, KeyAddr);
        check("wr_data", mem_wdata, {24'h0, wr_exp.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"}, mem_addr, 32'h0);
    check({tag, "_wren"}, 32'(mem_wren), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
    check({tag, "_rvalid"}, 32'(vga_rvalid), 32'd0);
    check({tag, "_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    vga_req   = 1'b0;
    vga_addr  = 32'h0;

    // 1: reset held three cycles, then idle.
    repeat (3) begin
      tick();
      check_reset_vals("rst_hold");
    end
    rst = 1'b0;
    repeat (3) begin
      tick();
      check_reset_vals("idle");
    end

    // 2: single key with no VGA traffic.
    key_valid = 1'b1;
    key_ascii = 8'h41;
    wr_exp.push_back(8'h41);
    tick();
    key_valid = 1'b0;
    key_ascii = 8'h00;
    check("k1_count_n1", 32'(fifo_count), 32'd1);
    check("k1_wren_n1", 32'(mem_wren), 32'd0);
    tick();
    check("k1_addr_n2", mem_addr, KeyAddr);
    check("k1_wren_n2", 32'(mem_wren), 32'd1);
    check("k1_wdata_n2", mem_wdata, 32'h41);
    check("k1_count_n2", 32'(fifo_count), 32'd0);
    tick();
    check("k1_wren_n3", 32'(mem_wren), 32'd0);

    // 3: back-to-back reads from 0x100.
    for (int i = 0; i <= 10; i++) begin
      vga_req  = (i < 8);
      vga_addr = 32'h100 + 32'(i);
      if (i < 8) rd_exp.push_back(vga_addr);
      check("rd_stream_rvalid", 32'(vga_rvalid), 32'((i >= 2) && (i <= 9)));
      check("rd_stream_wren", 32'(mem_wren), 32'd0);
      tick();
    end
    vga_req = 1'b0;

    // 4: starvation guard forces one write after 16 read grants with a pending key.
    for (int i = 0; i <= 22; i++) begin
      vga_req   = 1'b1;
      vga_addr  = 32'h200 + 32'(i);
      key_valid = (i == 0);
      key_ascii = (i == 0) ? 8'h62 : 8'h00;
      if (i == 0) wr_exp.push_back(8'h62);
      if (i != 17) rd_exp.push_back(vga_addr);
      check("starve_wren", 32'(mem_wren), 32'(i == 18));
      check("starve_rvalid", 32'(vga_rvalid), 32'((i >= 2) && (i != 19)));
      tick();
    end
    vga_req   = 1'b0;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    tick();
    tick();
    check("starve_rd_drained", 32'(rd_exp.size()), 32'd0);

    // 5: nine keys into an 8-deep FIFO while reads hold it off.
    for (int i = 0; i <= 9; i++) begin
      vga_req   = 1'b1;
      vga_addr  = 32'h300;
      key_valid = (i <= 8);
      key_ascii = (i <= 8) ? (8'h31 + 8'(i)) : 8'h00;
      if (i <= 7) wr_exp.push_back(key_ascii);
      rd_exp.push_back(vga_addr);
      tick();
    end
    vga_req   = 1'b0;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    check("ovf_count", 32'(fifo_count), 32'd8);
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    repeat (12) begin
      tick();
      check("ovf_sticky", 32'(overflow), 32'd1);
    end
    check("ovf_drain_count", 32'(fifo_count), 32'd0);
    check("ovf_drain_full", 32'(fifo_full), 32'd0);
    check("ovf_wr_drained", 32'(wr_exp.size()), 32'd0);

    // 6a: reset clears overflow; a zero key is ignored.
    rst = 1'b1;
    rd_exp.delete();
    wr_exp.delete();
    tick();
    rst = 1'b0;
    check_reset_vals("ovf_rst");
    key_valid = 1'b1;
    key_ascii = 8'h00;
    tick();
    key_valid = 1'b0;
    check("zero_key_count", 32'(fifo_count), 32'd0);
    check("zero_key_ovf", 32'(overflow), 32'd0);
    tick();
    check("zero_key_wren", 32'(mem_wren), 32'd0);

    // 6b: reset one cycle after a read grant discards the read and the FIFO.
    vga_req   = 1'b1;
    vga_addr  = 32'h400;
    key_valid = 1'b1;
    key_ascii = 8'h55;
    tick();
    vga_req   = 1'b0;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    check("mid_rst_addr_pre", mem_addr, 32'h400);
    check("mid_rst_count_pre", 32'(fifo_count), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("mid_rst");
    repeat (3) begin
      tick();
      check("post_rst_rvalid", 32'(vga_rvalid), 32'd0);
      check("post_rst_wren", 32'(mem_wren), 32'd0);
    end
    check("final_rd_q", 32'(rd_exp.size()), 32'd0);
    check("final_wr_q", 32'(wr_exp.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
